// File: rtl/axi4_pkg.sv
// -----------------------------------------------------------------------------
// axi4_pkg
// Shared constants for the AXI4 MMIO master: bus widths, AXI encodings,
// FSM state encoding and a response-merge helper.
// -----------------------------------------------------------------------------
package axi4_pkg;

    localparam int ADDR_W = 31;
    localparam int ID_W   = 4;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int LEN_W  = 8;

    localparam logic [2:0] AXI_SIZE_4B = 3'b010;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_AW   = 3'd1;
    localparam state_t ST_W    = 3'd2;
    localparam state_t ST_B    = 3'd3;
    localparam state_t ST_AR   = 3'd4;
    localparam state_t ST_R    = 3'd5;
    localparam state_t ST_DONE = 3'd6;

    // Keep the first non-OKAY response seen; otherwise take the new one.
    function automatic logic [1:0] merge_resp(input logic [1:0] cur,
                                              input logic [1:0] beat);
        logic [1:0] res;
        if (cur != RESP_OKAY) begin
            res = cur;
        end else begin
            res = beat;
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_mmio_master.sv
// -----------------------------------------------------------------------------
// axi4_mmio_master
// Converts single burst commands into AXI4 write (AW/W/B) or read (AR/R)
// transactions and reports one completion status per command.
//
// Ports
//   clock, resetn                  : clock, async active-low reset
//   cmd_*                          : command handshake (write flag, addr, len)
//   wd_*                           : write-data stream into the master
//   rd_*                           : read-data stream out of the master
//   done_*                         : completion status handshake
//   m_axi4_aw/w/b/ar/r_*           : AXI4 master channels
// -----------------------------------------------------------------------------
module axi4_mmio_master
    import axi4_pkg::*;
#(
    parameter logic [ID_W-1:0] ID = 4'h0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    input  logic [STRB_W-1:0] wd_strb,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [1:0]        done_resp,
    output logic              m_axi4_aw_valid,
    input  logic              m_axi4_aw_ready,
    output logic [ID_W-1:0]   m_axi4_aw_id,
    output logic [ADDR_W-1:0] m_axi4_aw_addr,
    output logic [LEN_W-1:0]  m_axi4_aw_len,
    output logic [2:0]        m_axi4_aw_size,
    output logic [1:0]        m_axi4_aw_burst,
    output logic              m_axi4_w_valid,
    input  logic              m_axi4_w_ready,
    output logic [DATA_W-1:0] m_axi4_w_data,
    output logic [STRB_W-1:0] m_axi4_w_strb,
    output logic              m_axi4_w_last,
    input  logic              m_axi4_b_valid,
    output logic              m_axi4_b_ready,
    input  logic [ID_W-1:0]   m_axi4_b_id,
    input  logic [1:0]        m_axi4_b_resp,
    output logic              m_axi4_ar_valid,
    input  logic              m_axi4_ar_ready,
    output logic [ID_W-1:0]   m_axi4_ar_id,
    output logic [ADDR_W-1:0] m_axi4_ar_addr,
    output logic [LEN_W-1:0]  m_axi4_ar_len,
    output logic [2:0]        m_axi4_ar_size,
    output logic [1:0]        m_axi4_ar_burst,
    input  logic              m_axi4_r_valid,
    output logic              m_axi4_r_ready,
    input  logic [ID_W-1:0]   m_axi4_r_id,
    input  logic [DATA_W-1:0] m_axi4_r_data,
    input  logic [1:0]        m_axi4_r_resp,
    input  logic              m_axi4_r_last
);

    state_t              state_r;
    state_t              next_state_s;
    logic                cmd_ready_r;
    logic                aw_valid_r;
    logic                ar_valid_r;
    logic                b_ready_r;
    logic                done_valid_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    cnt_r;
    logic [1:0]          resp_r;

    logic                in_w_s;
    logic                in_r_s;
    logic                cmd_accept_s;
    logic                w_beat_s;
    logic                r_beat_s;
    logic                b_hs_s;
    logic                cnt_zero_s;
    logic                r_proto_err_s;

    assign in_w_s       = (state_r == ST_W);
    assign in_r_s       = (state_r == ST_R);
    assign cnt_zero_s   = (cnt_r == 8'd0);
    assign cmd_accept_s = cmd_valid & cmd_ready_r;
    assign w_beat_s     = m_axi4_w_valid & m_axi4_w_ready;
    assign r_beat_s     = m_axi4_r_valid & m_axi4_r_ready;
    assign b_hs_s       = m_axi4_b_valid & b_ready_r;

    // A read beat is malformed if its ID is foreign or r_last disagrees with
    // the beat counter; such bursts still end only on r_last.
    assign r_proto_err_s = (m_axi4_r_id != ID) | (m_axi4_r_last ^ cnt_zero_s);

    assign cmd_ready       = cmd_ready_r;
    assign m_axi4_aw_valid = aw_valid_r;
    assign m_axi4_aw_id    = ID;
    assign m_axi4_aw_addr  = addr_r;
    assign m_axi4_aw_len   = len_r;
    assign m_axi4_aw_size  = AXI_SIZE_4B;
    assign m_axi4_aw_burst = BURST_INCR;
    assign m_axi4_ar_valid = ar_valid_r;
    assign m_axi4_ar_id    = ID;
    assign m_axi4_ar_addr  = addr_r;
    assign m_axi4_ar_len   = len_r;
    assign m_axi4_ar_size  = AXI_SIZE_4B;
    assign m_axi4_ar_burst = BURST_INCR;

    // Write data flows straight through, but only once AW has been accepted.
    assign m_axi4_w_valid  = in_w_s & wd_valid;
    assign wd_ready        = in_w_s & m_axi4_w_ready;
    assign m_axi4_w_data   = wd_data;
    assign m_axi4_w_strb   = wd_strb;
    assign m_axi4_w_last   = in_w_s & cnt_zero_s;
    assign m_axi4_b_ready  = b_ready_r;

    assign rd_valid        = in_r_s & m_axi4_r_valid;
    assign m_axi4_r_ready  = in_r_s & rd_ready;
    assign rd_data         = m_axi4_r_data;
    assign rd_last         = m_axi4_r_last;

    assign done_valid      = done_valid_r;
    assign done_resp       = resp_r;

    // Next-state selection for the burst FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_accept_s) begin
                    next_state_s = cmd_write ? ST_AW : ST_AR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_AW: begin
                if (m_axi4_aw_ready) begin
                    next_state_s = ST_W;
                end else begin
                    next_state_s = ST_AW;
                end
            end
            ST_W: begin
                if (w_beat_s && cnt_zero_s) begin
                    next_state_s = ST_B;
                end else begin
                    next_state_s = ST_W;
                end
            end
            ST_B: begin
                if (b_hs_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_B;
                end
            end
            ST_AR: begin
                if (m_axi4_ar_ready) begin
                    next_state_s = ST_R;
                end else begin
                    next_state_s = ST_AR;
                end
            end
            ST_R: begin
                if (r_beat_s && m_axi4_r_last) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_R;
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake outputs decoded from next state,
    // so each valid/ready is already high in the first cycle of its state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            cmd_ready_r  <= 1'b0;
            aw_valid_r   <= 1'b0;
            ar_valid_r   <= 1'b0;
            b_ready_r    <= 1'b0;
            done_valid_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            cmd_ready_r  <= (next_state_s == ST_IDLE);
            aw_valid_r   <= (next_state_s == ST_AW);
            ar_valid_r   <= (next_state_s == ST_AR);
            b_ready_r    <= (next_state_s == ST_B);
            done_valid_r <= (next_state_s == ST_DONE);
        end
    end

    // Command capture, beat counting and completion-status accumulation.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_r <= {ADDR_W{1'b0}};
            len_r  <= 8'd0;
            cnt_r  <= 8'd0;
            resp_r <= RESP_OKAY;
        end else begin
            if (cmd_accept_s) begin
                addr_r <= {cmd_addr[ADDR_W-1:2], 2'b00};
                len_r  <= cmd_len;
                cnt_r  <= cmd_len;
                resp_r <= RESP_OKAY;
            end else if (in_w_s && w_beat_s) begin
                cnt_r <= cnt_zero_s ? cnt_r : (cnt_r - 8'd1);
            end else if ((state_r == ST_B) && b_hs_s) begin
                resp_r <= (m_axi4_b_id != ID) ? RESP_SLVERR : m_axi4_b_resp;
            end else if (in_r_s && r_beat_s) begin
                cnt_r  <= cnt_zero_s ? cnt_r : (cnt_r - 8'd1);
                resp_r <= r_proto_err_s ? RESP_SLVERR
                                        : merge_resp(resp_r, m_axi4_r_resp);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule
